cpu_sequencer_fsm: RTL and testbench

CPU_SEQUENCER_FSM -- requirements
Module: cpu_sequencer_fsm

---
 rtl/cpu_sequencer_fsm.sv | 159 +++++++++++++++
 tb/tb_cpu_sequencer_fsm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer_fsm.sv
// Fetch/decode/execute sequencer for the accumulator CPU datapath.
// Optional STEP_MODE_EN: adds the Step port and a PAUSE state after each non-halting EXEC.
module cpu_sequencer_fsm #(
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                Clk,
  input  logic                CLB,
  input  logic [3:0]          Opcode,
  input  logic                Z,
  input  logic                C,
  input  logic                MemReady,
`ifdef STEP_MODE_EN
  input  logic                Step,
`endif
  output logic                MemRead,
  output logic                LoadIR,
  output logic                IncPC,
  output logic                SelPC,
  output logic                LoadPC,
  output logic                LoadReg,
  output logic                LoadAcc,
  output logic [1:0]          SelAcc,
  output logic [3:0]          SelALU,
  output logic [2:0]          State,
  output logic                Halted,
  output logic                IllegalOp,
  output logic [RETIRE_W-1:0] RetireCnt
);

  typedef enum logic [2:0] {
    FETCH  = 3'b000,
    DECODE = 3'b001,
    EXEC   = 3'b010,
    HALTED = 3'b011,
    PAUSE  = 3'b100
  } state_t;

  localparam logic [RETIRE_W-1:0] CNT_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

`ifdef STEP_MODE_EN
  localparam state_t AFTER_EXEC = PAUSE;
`else
  localparam state_t AFTER_EXEC = FETCH;
`endif

  state_t state, next;
  logic   retire;
  logic   illegal_hit;

  always_ff @(posedge Clk or negedge CLB) begin
    if (!CLB) state <= FETCH;
    else      state <= next;
  end

  always_ff @(posedge Clk or negedge CLB) begin
    if (!CLB)                           RetireCnt <= '0;
    else if (retire && RetireCnt != '1) RetireCnt <= RetireCnt + CNT_ONE;
  end

  always_ff @(posedge Clk or negedge CLB) begin
    if (!CLB)            IllegalOp <= 1'b0;
    else if (illegal_hit) IllegalOp <= 1'b1;
  end

  always_comb begin
    next        = state;
    MemRead     = 1'b0;
    LoadIR      = 1'b0;
    IncPC       = 1'b0;
    SelPC       = 1'b0;
    LoadPC      = 1'b0;
    LoadReg     = 1'b0;
    LoadAcc     = 1'b0;
    SelAcc      = '0;
    SelALU      = '0;
    Halted      = 1'b0;
    retire      = 1'b0;
    illegal_hit = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        if (MemReady) next = DECODE;
      end
      DECODE: begin
        LoadIR = 1'b1;
        next   = EXEC;
      end
      EXEC: begin
        SelALU = Opcode;
        next   = AFTER_EXEC;
        retire = 1'b1;
        case (Opcode)
          4'b0001, 4'b0010, 4'b0011, 4'b1011, 4'b1100: begin
            LoadAcc = 1'b1;
            SelAcc  = 2'b11;
            IncPC   = 1'b1;
          end
          4'b0100: begin
            LoadAcc = 1'b1;
            SelAcc  = 2'b01;
            IncPC   = 1'b1;
          end
          4'b0101: begin
            LoadReg = 1'b1;
            IncPC   = 1'b1;
          end
          4'b1101: begin
            LoadAcc = 1'b1;
            IncPC   = 1'b1;
          end
          4'b0000: IncPC = 1'b1;
          // Opcode[0] picks IMM for JMPZ, Opcode[1] picks IMM for JMPC
          4'b0110, 4'b0111: begin
            LoadPC = Z;
            IncPC  = ~Z;
            SelPC  = Z & Opcode[0];
          end
          4'b1000, 4'b1010: begin
            LoadPC = C;
            IncPC  = ~C;
            SelPC  = C & Opcode[1];
          end
          4'b1111: begin
            retire = 1'b0;
            next   = HALTED;
          end
          default: begin
            retire      = 1'b0;
            illegal_hit = 1'b1;
            next        = HALTED;
          end
        endcase
      end
      HALTED: Halted = 1'b1;
`ifdef STEP_MODE_EN
      PAUSE: if (Step) next = FETCH;
`endif
      default: next = FETCH;
    endcase
    // The state register already sits in FETCH during reset; mask FETCH's MemRead too.
    if (!CLB) begin
      MemRead     = 1'b0;
      LoadIR      = 1'b0;
      IncPC       = 1'b0;
      SelPC       = 1'b0;
      LoadPC      = 1'b0;
      LoadReg     = 1'b0;
      LoadAcc     = 1'b0;
      SelAcc      = '0;
      SelALU      = '0;
      Halted      = 1'b0;
      retire      = 1'b0;
      illegal_hit = 1'b0;
    end
  end

  assign State = state;

endmodule

// File: tb/tb_cpu_sequencer_fsm.sv
// Self-checking bench for cpu_sequencer_fsm: directed steps plus a random instruction
// stream, checked per cycle against an instruction-level reference model.
module tb_cpu_sequencer_fsm;

  localparam int RW      = 4;
  localparam int CNT_MAX = (1 << RW) - 1;

  localparam logic [2:0] ST_FETCH  = 3'b000;
  localparam logic [2:0] ST_DECODE = 3'b001;
  localparam logic [2:0] ST_EXEC   = 3'b010;
  localparam logic [2:0] ST_HALT   = 3'b011;
  localparam logic [2:0] ST_PAUSE  = 3'b100;

  logic          Clk = 1'b0;
  logic          CLB = 1'b1;
  logic [3:0]    Opcode = '0;
  logic          Z = 1'b0;
  logic          C = 1'b0;
  logic          MemReady = 1'b0;
`ifdef STEP_MODE_EN
  logic          Step = 1'b0;
`endif
  logic          MemRead, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0]    SelAcc;
  logic [3:0]    SelALU;
  logic [2:0]    State;
  logic          Halted, IllegalOp;
  logic [RW-1:0] RetireCnt;

  cpu_sequencer_fsm #(.RETIRE_W(RW)) dut (
    .Clk(Clk), .CLB(CLB), .Opcode(Opcode), .Z(Z), .C(C), .MemReady(MemReady),
`ifdef STEP_MODE_EN
    .Step(Step),
`endif
    .MemRead(MemRead), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC),
    .LoadPC(LoadPC), .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc),
    .SelALU(SelALU), .State(State), .Halted(Halted), .IllegalOp(IllegalOp),
    .RetireCnt(RetireCnt)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;
  bit m_illegal = 1'b0;

  // Observation order: State, MemRead, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
  // SelAcc, SelALU, Halted, IllegalOp, RetireCnt
  function automatic logic [21:0] mk(input logic [2:0] st, input logic [6:0] strobes,
                                     input logic [1:0] sacc, input logic [3:0] salu,
                                     input logic halted_o);
    logic [RW-1:0] cnt;
    cnt = RW'(m_cnt);
    return {st, strobes, sacc, salu, halted_o, m_illegal, cnt};
  endfunction

  function automatic bit is_illegal(input logic [3:0] op);
    return (op == 4'd9) || (op == 4'd14);
  endfunction

  function automatic bit is_halting(input logic [3:0] op);
    return is_illegal(op) || (op == 4'd15);
  endfunction

  function automatic logic [21:0] exec_exp(input logic [3:0] op, input logic z, input logic c);
    logic inc, selpc, lpc, lreg, lacc, flag;
    logic [1:0] sacc;
    inc = 0; selpc = 0; lpc = 0; lreg = 0; lacc = 0; sacc = 2'b00;
    case (op)
      4'd1, 4'd2, 4'd3, 4'd11, 4'd12: begin lacc = 1; sacc = 2'b11; inc = 1; end
      4'd4:  begin lacc = 1; sacc = 2'b01; inc = 1; end
      4'd5:  begin lreg = 1; inc = 1; end
      4'd13: begin lacc = 1; inc = 1; end
      4'd0:  inc = 1;
      4'd6, 4'd7, 4'd8, 4'd10: begin
        flag = (op == 4'd6 || op == 4'd7) ? z : c;
        if (flag) begin
          lpc   = 1;
          selpc = (op == 4'd7 || op == 4'd10);
        end else begin
          inc = 1;
        end
      end
      default: ;
    endcase
    return mk(ST_EXEC, {1'b0, 1'b0, inc, selpc, lpc, lreg, lacc}, sacc, op, 1'b0);
  endfunction

  task automatic check(input string tag, input logic [21:0] exp);
    logic [21:0] obs;
    obs = {State, MemRead, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
           SelAcc, SelALU, Halted, IllegalOp, RetireCnt};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    checks++;
    assert (!(IncPC === 1'b1 && LoadPC === 1'b1)) else begin
      errors++;
      $error("FAIL %s_pc_excl observed IncPC=%b LoadPC=%b expected not both 1", tag, IncPC, LoadPC);
    end
  endtask

  task automatic rand_inputs();
    Opcode   = 4'($urandom);
    Z        = 1'($urandom);
    C        = 1'($urandom);
    MemReady = 1'($urandom);
`ifdef STEP_MODE_EN
    Step     = 1'($urandom);
`endif
  endtask

  task automatic do_reset();
    @(negedge Clk);
    rand_inputs();
    Opcode    = 4'd1;
    CLB       = 1'b0;
    m_cnt     = 0;
    m_illegal = 1'b0;
    #1 check("reset_async", mk(ST_FETCH, 7'b0, 2'b00, 4'b0, 1'b0));
    repeat (2) begin
      @(negedge Clk);
      rand_inputs();
      #1 check("reset_hold", mk(ST_FETCH, 7'b0, 2'b00, 4'b0, 1'b0));
    end
  endtask

  task automatic fetch_decode(input logic [3:0] op, input int waits);
    for (int i = 0; i < waits; i++) begin
      @(negedge Clk);
      CLB = 1'b1;
      rand_inputs();
      MemReady = 1'b0;
      #1 check("fetch_wait", mk(ST_FETCH, 7'b1000000, 2'b00, 4'b0, 1'b0));
    end
    @(negedge Clk);
    CLB = 1'b1;
    rand_inputs();
    MemReady = 1'b1;
    #1 check("fetch", mk(ST_FETCH, 7'b1000000, 2'b00, 4'b0, 1'b0));
    @(negedge Clk);
    rand_inputs();
    Opcode = op;
    #1 check("decode", mk(ST_DECODE, 7'b0100000, 2'b00, 4'b0, 1'b0));
  endtask

  task automatic run_instr(input logic [3:0] op, input logic z, input logic c,
                           input int waits, input int hold);
    fetch_decode(op, waits);
    @(negedge Clk);
    rand_inputs();
    Opcode = op;
    Z = z;
    C = c;
    #1 check("exec", exec_exp(op, z, c));
    if (is_halting(op)) begin
      if (is_illegal(op)) m_illegal = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge Clk);
        rand_inputs();
        #1 check("halted", mk(ST_HALT, 7'b0, 2'b00, 4'b0, 1'b1));
      end
    end else begin
      if (m_cnt < CNT_MAX) m_cnt++;
`ifdef STEP_MODE_EN
      begin
        int n;
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
          @(negedge Clk);
          rand_inputs();
          Step = 1'b0;
          #1 check("pause_hold", mk(ST_PAUSE, 7'b0, 2'b00, 4'b0, 1'b0));
        end
        @(negedge Clk);
        rand_inputs();
        Step = 1'b1;
        #1 check("pause_go", mk(ST_PAUSE, 7'b0, 2'b00, 4'b0, 1'b0));
      end
`endif
    end
  endtask

  initial begin
    do_reset();

    // First instruction straight out of reset: LoadIR in cycle 2, EXEC in cycle 3
    run_instr(4'd1, 1'b0, 1'b0, 0, 0);

    // Conditional jumps, taken and not taken
    run_instr(4'd7,  1'b1, 1'b0, 0, 0);
    run_instr(4'd7,  1'b0, 1'b1, 0, 0);
    run_instr(4'd6,  1'b1, 1'b0, 0, 0);
    run_instr(4'd6,  1'b0, 1'b1, 0, 0);
    run_instr(4'd8,  1'b0, 1'b1, 0, 0);
    run_instr(4'd8,  1'b1, 1'b0, 0, 0);
    run_instr(4'd10, 1'b0, 1'b1, 0, 0);
    run_instr(4'd10, 1'b1, 1'b0, 0, 0);

    // Memory stall in FETCH
    run_instr(4'd0, 1'b0, 1'b0, 5, 0);

    // Every datapath opcode once
    run_instr(4'd2,  1'b1, 1'b1, 1, 0);
    run_instr(4'd3,  1'b0, 1'b0, 0, 0);
    run_instr(4'd4,  1'b1, 1'b0, 0, 0);
    run_instr(4'd5,  1'b0, 1'b1, 2, 0);
    run_instr(4'd11, 1'b1, 1'b1, 0, 0);
    run_instr(4'd12, 1'b0, 1'b0, 0, 0);
    run_instr(4'd13, 1'b1, 1'b0, 0, 0);

    // Retire counter saturation
    for (int i = 0; i < 8; i++) run_instr(4'd0, 1'($urandom), 1'($urandom), 0, 0);

    // Illegal opcode: sticky flag, halted for 20 cycles, then cleared by reset
    run_instr(4'd14, 1'b0, 1'b0, 0, 20);
    do_reset();
    run_instr(4'd0, 1'b0, 1'b0, 0, 0);
    run_instr(4'd9, 1'b1, 1'b1, 0, 5);
    do_reset();
    run_instr(4'd15, 1'b0, 1'b0, 1, 6);
    do_reset();

    // Reset in the middle of an instruction abandons it
    run_instr(4'd1, 1'b0, 1'b0, 0, 0);
    fetch_decode(4'd1, 0);
    do_reset();
    run_instr(4'd4, 1'b0, 1'b0, 0, 0);

    // Random instruction stream
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      op = 4'($urandom);
      run_instr(op, 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(1, 4));
      if (is_halting(op)) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=no_finish expected=finish");
    $fatal(1, "timeout");
  end

endmodule
